// File: rtl/amba3_apb_regfile_pkg.sv
// Shared types and helpers for the APB3 register file.
// Also used by the BFM-side scoreboard for word-index math.
package pkg_amba3;

  typedef enum logic [0:0] {
    APB_IDLE,
    APB_ACCESS
  } apb_state_e;

  function automatic logic [63:0] apb_word_index(
    input logic [63:0] addr,
    input int          data_bits
  );
    return addr >> $clog2(data_bits / 8);
  endfunction

endpackage

// File: rtl/amba3_apb_reg_bank.sv
// Register storage, write-enable decode and write strobes.
// Strobe bit i pulses for one cycle after register i is committed.
module amba3_apb_reg_bank
  import pkg_amba3::*;
#(
  parameter int DATA_BITS = 32,
  parameter int NUM_REGS  = 16,
  parameter int IDX_W     = 4
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic                          we,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DATA_BITS-1:0]          wdata,
  output logic [NUM_REGS*DATA_BITS-1:0] reg_q,
  output logic [NUM_REGS-1:0]           wr_stb
);

  logic [DATA_BITS-1:0] regs [NUM_REGS];

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_stb <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_stb[i] <= we && (idx == IDX_W'(i));
        if (we && (idx == IDX_W'(i))) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_q[g*DATA_BITS +: DATA_BITS] = regs[g];
  end

endmodule

// File: rtl/amba3_apb_regfile.sv
// APB3 slave register file with programmable wait states.
// Optional pslverr on decode miss: define AMBA3_APB_PSLVERR_EN.
module amba3_apb_regfile
  import pkg_amba3::*;
#(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [ADDR_BITS-1:0]          paddr,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [DATA_BITS-1:0]          pwdata,
  output logic                          pready,
  output logic [DATA_BITS-1:0]          prdata,
`ifdef AMBA3_APB_PSLVERR_EN
  output logic                          pslverr,
`endif
  output logic [NUM_REGS*DATA_BITS-1:0] reg_q,
  output logic [NUM_REGS-1:0]           wr_stb
);

  localparam int IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] WAIT8 = 8'(WAIT_CYCLES);

  apb_state_e           state;
  logic [7:0]           cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 wr_q;
  logic [DATA_BITS-1:0] wdata_q;

  logic [ADDR_BITS-1:0] addr_s;
  logic                 wr_s;
  logic [63:0]          widx;
  logic [IDX_W-1:0]     idx;
  logic                 miss;
  logic [DATA_BITS-1:0] rsel;
  logic                 setup;
  logic                 tick;
  logic                 done;
  logic                 abort;
  logic                 set_rdy;
  logic                 clr_rdy;
  logic                 we;

  // With no wait states pready rises at the setup edge, so decode
  // must look at the live bus in IDLE and the latched copy after.
  assign addr_s = (state == APB_IDLE) ? paddr : addr_q;
  assign wr_s   = (state == APB_IDLE) ? pwrite : wr_q;
  assign widx   = apb_word_index(64'(addr_s), DATA_BITS);
  assign idx    = widx[IDX_W-1:0];
  assign miss   = widx >= 64'(NUM_REGS);
  assign rsel   = reg_q[idx*DATA_BITS +: DATA_BITS];

  assign setup = (state == APB_IDLE) && psel && !penable;
  assign tick  = (state == APB_ACCESS) && psel
              && penable && !pready;
  assign done  = (state == APB_ACCESS) && psel
              && penable && pready;
  assign abort = (state == APB_ACCESS) && !psel;

  assign set_rdy = (setup && (WAIT_CYCLES == 0))
                || (tick && (cnt == 8'd1));
  assign clr_rdy = done || abort;
  assign we      = done && wr_q && !miss;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= APB_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
    end else begin
      unique case (state)
        APB_IDLE: begin
          if (setup) begin
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            cnt     <= WAIT8;
            state   <= APB_ACCESS;
          end
        end
        APB_ACCESS: begin
          if (abort || done) begin
            state <= APB_IDLE;
          end else if (tick) begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= APB_IDLE;
      endcase
      if (set_rdy) begin
        pready <= 1'b1;
        prdata <= (!wr_s && !miss) ? rsel : '0;
      end else if (clr_rdy) begin
        pready <= 1'b0;
        prdata <= '0;
      end
    end
  end

`ifdef AMBA3_APB_PSLVERR_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pslverr <= 1'b0;
    end else if (set_rdy) begin
      pslverr <= miss;
    end else if (clr_rdy) begin
      pslverr <= 1'b0;
    end
  end
`endif

  amba3_apb_reg_bank #(
    .DATA_BITS (DATA_BITS),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_bank (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (we),
    .idx      (idx),
    .wdata    (wdata_q),
    .reg_q    (reg_q),
    .wr_stb   (wr_stb)
  );

endmodule

// File: tb/tb_amba3_apb_regfile.sv
// Scoreboard bench: two DUTs (0 and 3 wait states) on one APB bus.
// A negedge monitor pops expected responses as transfers complete.
module tb_amba3_apb_regfile;

  logic        pclk;
  logic        preset_n;
  logic [31:0] paddr;
  logic        psel0;
  logic        psel3;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pr0, pr3;
  logic [31:0] rd0, rd3;
  logic [511:0] rq0, rq3;
  logic [15:0] ws0, ws3;
`ifdef AMBA3_APB_PSLVERR_EN
  logic        er0, er3;
`endif

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          stall;
  logic [511:0] m0, m3;

  amba3_apb_regfile #(.WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr),
    .psel(psel0), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pr0), .prdata(rd0),
`ifdef AMBA3_APB_PSLVERR_EN
    .pslverr(er0),
`endif
    .reg_q(rq0), .wr_stb(ws0)
  );

  amba3_apb_regfile #(.WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr),
    .psel(psel3), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pr3), .prdata(rd3),
`ifdef AMBA3_APB_PSLVERR_EN
    .pslverr(er3),
`endif
    .reg_q(rq3), .wr_stb(ws3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic void chk(
    input string nm,
    input logic [511:0] act,
    input logic [511:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge pclk) begin
    exp_t e;
    if ((psel0 || psel3) && penable) begin
      if (!(psel3 ? pr3 : pr0)) begin
        stall++;
      end else begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got response expected none");
        end else begin
          e = sb.pop_front();
          chk("prdata", psel3 ? rd3 : rd0, e.rdata);
          chk("waits", stall, e.waits);
`ifdef AMBA3_APB_PSLVERR_EN
          chk("pslverr", psel3 ? er3 : er0, e.err);
`endif
        end
        stall = 0;
      end
    end else begin
      stall = 0;
    end
  end

  task automatic xfer(
    input bit          d,
    input logic [31:0] a,
    input bit          w,
    input logic [31:0] dat,
    input logic [31:0] exp_rd
  );
    exp_t        e;
    int          n;
    bit          hit;
    logic [15:0] stb;
    hit     = a < 32'h40;
    e.rdata = exp_rd;
    e.err   = !hit;
    e.waits = d ? 3 : 0;
    sb.push_back(e);
    stb = '0;
    if (w && hit) stb[a[5:2]] = 1'b1;
    psel0   = !d;
    psel3   = d;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = dat;
    @(posedge pclk); #1;
    chk("stb_setup", d ? ws3 : ws0, 16'h0);
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~dat;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!(d ? pr3 : pr0) && n < 40);
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: got 0 expected 1");
    end
    @(posedge pclk); #1;
    chk("wr_stb", d ? ws3 : ws0, stb);
    if (w && hit) begin
      if (d) m3[a[5:2]*32 +: 32] = dat;
      else   m0[a[5:2]*32 +: 32] = dat;
    end
    chk("reg_q", d ? rq3 : rq0, d ? m3 : m0);
  endtask

  task automatic idle();
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    chk("stb_clear", {ws3, ws0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    errors   = 0;
    stall    = 0;
    m0       = '0;
    m3       = '0;
    preset_n = 1'b0;
    psel0    = 1'b0;
    psel3    = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_regs", {rq3, rq0}, '0);
    chk("rst_out", {pr3, pr0, rd3, rd0, ws3, ws0}, '0);
    preset_n = 1'b1;
    @(posedge pclk); #1;

    xfer(0, 32'h08, 1, 32'hDEADBEEF, 32'h0);
    idle();
    xfer(0, 32'h08, 0, 32'h0, 32'hDEADBEEF);
    idle();
    xfer(1, 32'h00, 0, 32'h0, 32'h0);
    idle();
    xfer(0, 32'h40, 1, 32'h1234, 32'h0);
    xfer(0, 32'h40, 0, 32'h0, 32'h0);
    idle();
    xfer(0, 32'h0B, 0, 32'h0, 32'hDEADBEEF);
    idle();
    xfer(0, 32'h1000_0008, 0, 32'h0, 32'h0);
    idle();
    xfer(0, 32'h00, 1, 32'h1, 32'h0);
    xfer(0, 32'h04, 1, 32'h2, 32'h0);
    xfer(0, 32'h00, 0, 32'h0, 32'h1);
    xfer(0, 32'h04, 0, 32'h0, 32'h2);
    idle();
    xfer(1, 32'h0C, 1, 32'hA5A5A5A5, 32'h0);
    xfer(1, 32'h0C, 0, 32'h0, 32'hA5A5A5A5);
    idle();

    psel3   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0C;
    pwdata  = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel3   = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk("abort_rdy0", pr3, 1'b0);
    @(posedge pclk); #1;
    chk("abort_rdy1", pr3, 1'b0);
    chk("abort_reg", rq3, m3);
    chk("abort_stb", ws3, 16'h0);
    xfer(1, 32'h0C, 0, 32'h0, 32'hA5A5A5A5);
    idle();

    psel3   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0C;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    preset_n = 1'b0;
    #1;
    m0 = '0;
    m3 = '0;
    chk("arst_regs", {rq3, rq0}, '0);
    chk("arst_out", {pr3, pr0, rd3, rd0, ws3, ws0}, '0);
    psel3   = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(posedge pclk); #1;
    xfer(0, 32'h08, 0, 32'h0, 32'h0);
    idle();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
